// File: rtl/sap_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : sap_prog_loader
// Description : Program-memory writer for the SAP CPU.
//               - Accepts a framed byte stream over a valid/ready handshake.
//               - Writes the payload into program memory starting at address 0.
//               - Holds the CPU in clear (cpu_clr_ low) until a complete,
//                 valid frame has been loaded.
//
//               Frame format: SYNC_BYTE, LEN (1..2**ADDR_W), LEN data bytes,
//               then an optional CSUM byte.
//
//               Optional feature macro: CHECKSUM_EN
//                 defined   : a CSUM byte follows the data. The frame is good
//                             only if (sum of data + CSUM) mod 2**DATA_W == 0.
//                 undefined : there is no CSUM byte. The only error is a bad
//                             LEN.
//
// Ports       : clk        - system clock, rising edge
//               clr_       - synchronous active-low reset
//               in_data    - stream byte
//               in_valid   - in_data valid
//               in_ready   - loader can accept a byte
//               mem_we     - memory write strobe (one cycle per data byte)
//               mem_addr   - memory write address
//               mem_wdata  - memory write data
//               cpu_clr_   - active-low clear to the CPU
//               load_busy  - frame in progress
//               load_done  - sticky: last frame loaded OK
//               load_err   - sticky: last frame rejected
//               load_count - data bytes written in the current/last frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module sap_prog_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              clr_,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_clr_,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    localparam int              c_DEPTH   = 2 ** ADDR_W;
    localparam logic [DATA_W:0] c_MAX_LEN = c_DEPTH[DATA_W:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_clr_n;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_accept;
    logic [DATA_W:0]     w_len_ext;
    logic [ADDR_W:0]     w_count_nxt;

    assign w_accept    = in_valid & r_in_ready;
    assign w_len_ext   = {1'b0, in_data};
    assign w_count_nxt = r_count + 1'b1;

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   w_sum_nxt;
    logic [DATA_W-1:0]   w_sum_chk;

    assign w_sum_nxt = r_sum + in_data;
    // The sum check is the same addition as the running sum, applied to the
    // CSUM byte.
    assign w_sum_chk = w_sum_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!clr_) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_clr_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_len       <= '0;
            r_addr      <= '0;
`ifdef CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse following each
            // accepted data byte.
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Bytes other than SYNC are accepted and dropped. This
                    // lets the loader resynchronise on a noisy line.
                    if (w_accept && (in_data == SYNC_BYTE)) begin
                        r_state     <= S_LEN;
                        r_cpu_clr_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_count     <= '0;
`ifdef CHECKSUM_EN
                        r_sum       <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if ((w_len_ext == '0) || (w_len_ext > c_MAX_LEN)) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_len   <= in_data[ADDR_W:0];
                            r_addr  <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= in_data;
                        r_mem_addr  <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        r_count     <= w_count_nxt;
`ifdef CHECKSUM_EN
                        r_sum       <= w_sum_nxt;
                        if (w_count_nxt == r_len) begin
                            r_state <= S_CSUM;
                        end
`else
                        if (w_count_nxt == r_len) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                        end
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_state    <= (w_sum_chk == '0) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE: begin
                    r_cpu_clr_n <= 1'b1;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ERR: begin
                    // The CPU stays in clear. Memory contents already written
                    // are left as they are.
                    r_err      <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    // Gating with clr_ suppresses a write that is already scheduled for the
    // cycle in which reset is asserted.
    assign mem_we     = r_mem_we & clr_;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_clr_   = r_cpu_clr_n;
    assign load_busy  = r_busy;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sap_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_prog_loader
// Description : Self-checking bench for sap_prog_loader.
//               - Uses a table of frames with hand-computed expected results.
//               - Hand-written sequences cover reset, write latency, reset in
//                 the middle of a frame, and re-clearing the CPU on a new
//                 frame.
//               - Vectors adapt to the CHECKSUM_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_prog_loader;

    logic       clk;
    logic       clr_;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_clr_;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic [4:0] load_count;

    int n_vec  = 0;
    int n_miss = 0;

    sap_prog_loader dut (
        .clk        (clk),
        .clr_       (clr_),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_clr_   (cpu_clr_),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log of memory writes, recorded away from the active edge
    logic [11:0] wr_log[$];
    always @(negedge clk) begin
        if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        logic [7:0] b [0:23];
        int         n;
        int         gap_at;
        int         data_off;
        int         nwr;
        logic       exp_done;
        logic       exp_err;
        logic [4:0] exp_count;
    } vec_t;

    vec_t tbl [0:5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte and hold it until it is taken at a clock edge.
    // Returns at the edge + 1 time unit, with in_valid dropped.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL send_timeout: byte %0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (load_done || load_err) seen = 1'b1;
        end
        chk("frame_end_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic add(input int v, input logic [7:0] b);
        tbl[v].b[tbl[v].n] = b;
        tbl[v].n = tbl[v].n + 1;
    endtask

    task automatic init_vec(input int v, input int data_off, input int nwr,
                            input logic done, input logic err, input logic [4:0] cnt);
        tbl[v].n         = 0;
        tbl[v].gap_at    = -1;
        tbl[v].data_off  = data_off;
        tbl[v].nwr       = nwr;
        tbl[v].exp_done  = done;
        tbl[v].exp_err   = err;
        tbl[v].exp_count = cnt;
    endtask

    initial begin
        logic [7:0] big [0:15];
        logic [7:0] sum_chk;

        // ---------------- table setup ----------------
        // 0: good frame of three bytes
        init_vec(0, 2, 3, 1'b1, 1'b0, 5'd3);
        add(0, 8'hA5); add(0, 8'h03); add(0, 8'h01); add(0, 8'h02); add(0, 8'h03);
`ifdef CHECKSUM_EN
        add(0, 8'hFA);
`endif
        // 1: bad checksum (or a plain good frame when there is no checksum)
`ifdef CHECKSUM_EN
        init_vec(1, 2, 2, 1'b0, 1'b1, 5'd2);
        add(1, 8'hA5); add(1, 8'h02); add(1, 8'h10); add(1, 8'h20); add(1, 8'h00);
`else
        init_vec(1, 2, 2, 1'b1, 1'b0, 5'd2);
        add(1, 8'hA5); add(1, 8'h02); add(1, 8'h10); add(1, 8'h20);
`endif
        // 2: LEN = 0 is rejected
        init_vec(2, 2, 0, 1'b0, 1'b1, 5'd0);
        add(2, 8'hA5); add(2, 8'h00);
        // 3: LEN = 0x11 is rejected
        init_vec(3, 2, 0, 1'b0, 1'b1, 5'd0);
        add(3, 8'hA5); add(3, 8'h11);
        // 4: noise before SYNC, then a three-cycle gap before the data byte
        init_vec(4, 4, 1, 1'b1, 1'b0, 5'd1);
        add(4, 8'h00); add(4, 8'hFF); add(4, 8'hA5); add(4, 8'h01); add(4, 8'h7E);
`ifdef CHECKSUM_EN
        add(4, 8'h82);
`endif
        tbl[4].gap_at = 4;
        // 5: full 16-byte frame; byte 5 equals SYNC and must be treated as data
        big = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h66, 8'h77,
                8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        sum_chk = 8'hB8;  // 0x848 mod 256 = 0x48; 0x100 - 0x48 = 0xB8
        init_vec(5, 2, 16, 1'b1, 1'b0, 5'd16);
        add(5, 8'hA5); add(5, 8'h10);
        for (int i = 0; i < 16; i++) add(5, big[i]);
`ifdef CHECKSUM_EN
        add(5, sum_chk);
`endif

        // ---------------- reset ----------------
        clr_     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_clr", {31'd0, cpu_clr_},  32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we},     32'd0);
        chk("rst_done", {31'd0, load_done},    32'd0);
        chk("rst_err", {31'd0, load_err},      32'd0);
        chk("rst_busy", {31'd0, load_busy},    32'd0);
        chk("rst_count", {27'd0, load_count},  32'd0);
        chk("rst_addr", {28'd0, mem_addr},     32'd0);
        chk("rst_wdata", {24'd0, mem_wdata},   32'd0);
        @(posedge clk);
        #1 clr_ = 1'b1;

        // ---------------- write latency and reset mid-frame ----------------
        wr_log.delete();
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        @(negedge clk);
        chk("lat_we", {31'd0, mem_we},        32'd1);
        chk("lat_addr", {28'd0, mem_addr},    32'd0);
        chk("lat_wdata", {24'd0, mem_wdata},  32'h11);
        chk("lat_count", {27'd0, load_count}, 32'd1);
        chk("lat_busy", {31'd0, load_busy},   32'd1);
        send(8'h22);
        clr_ = 1'b0;
        @(negedge clk);
        chk("midrst_we_suppressed", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 clr_ = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, load_busy},    32'd0);
        chk("midrst_cpu_clr", {31'd0, cpu_clr_},  32'd0);
        chk("midrst_count", {27'd0, load_count},  32'd0);
        chk("midrst_ready", {31'd0, in_ready},    32'd1);
        chk("midrst_nwrites", wr_log.size(),      32'd1);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 6; v++) begin
            wr_log.delete();
            for (int i = 0; i < tbl[v].n; i++) begin
                if (i == tbl[v].gap_at) repeat (3) @(posedge clk);
                if (i == tbl[v].gap_at) #1;
                send(tbl[v].b[i]);
            end
            wait_end();
            chk($sformatf("v%0d_done", v), {31'd0, load_done}, {31'd0, tbl[v].exp_done});
            chk($sformatf("v%0d_err", v),  {31'd0, load_err},  {31'd0, tbl[v].exp_err});
            chk($sformatf("v%0d_cpu_clr", v), {31'd0, cpu_clr_}, {31'd0, tbl[v].exp_done});
            chk($sformatf("v%0d_busy", v), {31'd0, load_busy}, 32'd0);
            chk($sformatf("v%0d_ready", v), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d_count", v), {27'd0, load_count}, {27'd0, tbl[v].exp_count});
            chk($sformatf("v%0d_nwrites", v), wr_log.size(), tbl[v].nwr);
            for (int i = 0; i < tbl[v].nwr && i < wr_log.size(); i++) begin
                logic [3:0] ea;
                ea = i[3:0];
                chk($sformatf("v%0d_write%0d", v, i), {20'd0, wr_log[i]},
                    {20'd0, ea, tbl[v].b[tbl[v].data_off + i]});
            end
        end

        // ---------------- new frame after DONE re-clears the CPU ----------------
        send(8'hA5);
        @(negedge clk);
        chk("reclr_cpu_clr", {31'd0, cpu_clr_}, 32'd0);
        chk("reclr_busy", {31'd0, load_busy},   32'd1);
        chk("reclr_done", {31'd0, load_done},   32'd0);
        send(8'h01);
        send(8'h5A);
`ifdef CHECKSUM_EN
        send(8'hA6);
`endif
        wait_end();
        chk("reclr_final_done", {31'd0, load_done},   32'd1);
        chk("reclr_final_cpu_clr", {31'd0, cpu_clr_}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
